msg_framer_1553: RTL and testbench

Receive-side message framer between `decoder_1553` and the receive FIFO, clocked on `dec_clk`. Consumes decoded words (`rx_dword`, `rx_dval`, `rx_csw`, `rx_dw`, `rx_perr`) and groups them into MIL-STD-1553 messages by parsing each command word. Filters on RT address, checks word count, inter-word gap and parity, and writes tagged 20-bit entries (first/last/error markers) to the FIFO write port.

---
 rtl/msg_framer_1553.sv | 119 +++++++++++
 tb/tb_msg_framer_1553.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/msg_framer_1553.sv
// msg_framer_1553: groups decoded 1553 words into tagged FIFO messages with RT filtering and error markers.
// Optional: define BCAST_EN to accept RT address 31 as broadcast.
module msg_framer_1553 #(
  parameter int GAP_CYCLES = 200,
  parameter int CNT_W = 16
) (
  input  logic             dec_clk,
  input  logic             rst_n,
  input  logic [15:0]      rx_dword,
  input  logic             rx_dval,
  input  logic             rx_csw,
  input  logic             rx_dw,
  input  logic             rx_perr,
  input  logic [4:0]       rt_addr,
  input  logic             fifo_full,
  output logic             fifo_wren,
  output logic [19:0]      fifo_din,
  output logic             msg_done,
  output logic             msg_err,
  output logic [2:0]       err_code,
  output logic [CNT_W-1:0] msg_cnt
);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, DATA, IGNORE, ERRW} state_t;
  state_t state;
  logic [GW-1:0] gap;
  logic [5:0] left, nexp;
  logic [15:0] held, cmd;
  logic pend, bcast, match, mode;
  // a superseding command is parked in held and replayed once its marker is out
  assign cmd = pend ? held : rx_dword;
`ifdef BCAST_EN
  assign bcast = cmd[15:11] == 5'd31;
`else
  assign bcast = 1'b0;
`endif
  assign match = cmd[15:11] == rt_addr || bcast;
  assign mode = cmd[9:5] == 5'd0 || cmd[9:5] == 5'd31;
  assign nexp = cmd[10] ? 6'd0 : mode ? {5'd0, cmd[4]} : {cmd[4:0] == 5'd0, cmd[4:0]};
  always_ff @(posedge dec_clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      gap <= '0;
      left <= '0;
      held <= '0;
      pend <= 1'b0;
      fifo_wren <= 1'b0;
      fifo_din <= '0;
      msg_done <= 1'b0;
      msg_err <= 1'b0;
      err_code <= '0;
      msg_cnt <= '0;
    end else begin
      fifo_wren <= 1'b0;
      msg_done <= 1'b0;
      msg_err <= 1'b0;
      gap <= (rx_dval || state != DATA) ? '0 : gap + 1'b1;
      case (state)
        IDLE, IGNORE:
          if (pend || (rx_dval && rx_csw && !rx_perr)) begin
            pend <= 1'b0;
            if (!match) state <= IGNORE;
            else if (bcast && cmd[10]) begin
              state <= ERRW;
              err_code <= 3'd3;
            end else if (fifo_full) begin
              state <= ERRW;
              err_code <= 3'd4;
            end else begin
              fifo_wren <= 1'b1;
              fifo_din <= {nexp == 6'd0, 3'b110, cmd};
              left <= nexp;
              state <= nexp == 6'd0 ? IDLE : DATA;
              if (nexp == 6'd0) begin
                msg_done <= 1'b1;
                msg_cnt <= msg_cnt + 1'b1;
              end
            end
          end else if (rx_dval && state == IDLE && (rx_perr || rx_dw)) begin
            state <= ERRW;
            err_code <= rx_perr ? 3'd1 : 3'd3;
          end
        DATA:
          if (rx_dval && rx_perr) begin
            state <= ERRW;
            err_code <= 3'd1;
          end else if (rx_dval && rx_csw) begin
            state <= ERRW;
            err_code <= 3'd5;
            held <= rx_dword;
          end else if (rx_dval && rx_dw) begin
            if (fifo_full) begin
              state <= ERRW;
              err_code <= 3'd4;
            end else begin
              fifo_wren <= 1'b1;
              fifo_din <= {left == 6'd1, 3'b001, rx_dword};
              left <= left - 1'b1;
              if (left == 6'd1) begin
                state <= IDLE;
                msg_done <= 1'b1;
                msg_cnt <= msg_cnt + 1'b1;
              end
            end
          end else if (gap == GW'(GAP_CYCLES)) begin
            state <= ERRW;
            err_code <= 3'd2;
          end
        ERRW:
          if (!fifo_full) begin
            fifo_wren <= 1'b1;
            msg_err <= 1'b1;
            fifo_din <= {4'b0011, 13'd0, err_code};
            state <= err_code == 3'd1 ? IGNORE : IDLE;
            pend <= err_code == 3'd5;
          end
      endcase
    end
endmodule

// File: tb/tb_msg_framer_1553.sv
// tb_msg_framer_1553: directed and randomized message streams checked against a message-level model.
module tb_msg_framer_1553;
  localparam int CW = 4;
  logic dec_clk = 1'b0, rst_n = 1'b0;
  logic [15:0] rx_dword = '0;
  logic rx_dval = 1'b0, rx_csw = 1'b0, rx_dw = 1'b0, rx_perr = 1'b0;
  logic [4:0] rt_addr = 5'd5;
  logic fifo_full = 1'b0;
  logic fifo_wren, msg_done, msg_err;
  logic [19:0] fifo_din;
  logic [2:0] err_code;
  logic [CW-1:0] msg_cnt;
  int n_assert = 0, n_fail = 0, n_done = 0, n_err = 0, e_done = 0, e_err = 0, rp = 0;
  logic [CW-1:0] e_cnt = '0;
  logic [2:0] e_code = '0;
  logic [19:0] got[$], exp_q[$];
  logic ign = 1'b0;
  logic [15:0] c, w;
  int n, k, kind;

  always #5 dec_clk = ~dec_clk;

  msg_framer_1553 #(.GAP_CYCLES(200), .CNT_W(CW)) dut (
    .dec_clk(dec_clk), .rst_n(rst_n), .rx_dword(rx_dword), .rx_dval(rx_dval),
    .rx_csw(rx_csw), .rx_dw(rx_dw), .rx_perr(rx_perr), .rt_addr(rt_addr),
    .fifo_full(fifo_full), .fifo_wren(fifo_wren), .fifo_din(fifo_din),
    .msg_done(msg_done), .msg_err(msg_err), .err_code(err_code), .msg_cnt(msg_cnt)
  );

  always @(negedge dec_clk)
    if (rst_n) begin
      if (fifo_wren) got.push_back(fifo_din);
      if (msg_done) n_done++;
      if (msg_err) n_err++;
    end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic int n_data(input logic [15:0] cw);
    int sa = int'(cw[9:5]);
    int wc = int'(cw[4:0]);
    if (cw[10]) return 0;
    if (sa == 0 || sa == 31) return wc >= 16 ? 1 : 0;
    return wc == 0 ? 32 : wc;
  endfunction

  function automatic logic [15:0] rcv_cmd(input logic [4:0] rt);
    return {rt, 1'b0, 5'($urandom_range(1, 30)), 5'($urandom_range(2, 32))};
  endfunction

  task automatic good_msg();
    e_cnt++;
    e_done++;
  endtask

  task automatic exp_mark(input int code);
    exp_q.push_back({4'b0011, 13'd0, 3'(code)});
    e_code = 3'(code);
    e_err++;
  endtask

  task automatic send(input logic [15:0] v, input logic cs, input logic ds, input logic p, input int g);
    @(negedge dec_clk);
    rx_dword = v; rx_csw = cs; rx_dw = ds; rx_perr = p; rx_dval = 1'b1;
    @(negedge dec_clk);
    rx_dval = 1'b0; rx_csw = 1'b0; rx_dw = 1'b0; rx_perr = 1'b0;
    repeat (g) @(negedge dec_clk);
  endtask

  // command plus the first cnt of its data words, none of them final
  task automatic partial(input logic [15:0] cw, input int cnt);
    logic [15:0] v;
    send(cw, 1'b1, 1'b0, 1'b0, $urandom_range(1, 6));
    exp_q.push_back({n_data(cw) == 0, 3'b110, cw});
    if (n_data(cw) == 0) good_msg();
    for (int i = 0; i < cnt; i++) begin
      v = 16'($urandom);
      send(v, 1'b0, 1'b1, 1'b0, $urandom_range(1, 6));
      exp_q.push_back({i == n_data(cw) - 1, 3'b001, v});
      if (i == n_data(cw) - 1) good_msg();
    end
  endtask

  task automatic own_msg(input logic [15:0] cw);
    partial(cw, n_data(cw));
  endtask

  task automatic junk(input int cnt);
    for (int i = 0; i < cnt; i++) send(16'($urandom), 1'b0, 1'b1, 1'b0, $urandom_range(1, 4));
  endtask

  task automatic settle(input int cyc, input string tag);
    repeat (cyc) @(negedge dec_clk);
    check({tag, "/entries"}, got.size() - rp, exp_q.size());
    foreach (exp_q[i]) check(tag, (rp + i < got.size()) ? got[rp + i] : 20'hxxxxx, exp_q[i]);
    rp = got.size();
    exp_q.delete();
    check({tag, "/msg_cnt"}, msg_cnt, e_cnt);
    check({tag, "/err_code"}, err_code, e_code);
    check({tag, "/done_pulses"}, n_done, e_done);
    check({tag, "/err_pulses"}, n_err, e_err);
  endtask

  initial begin
    repeat (3) @(negedge dec_clk);
    check("rst/wren", fifo_wren, 0);
    check("rst/din", fifo_din, 0);
    check("rst/done", msg_done, 0);
    check("rst/err", msg_err, 0);
    check("rst/code", err_code, 0);
    check("rst/cnt", msg_cnt, 0);
    rst_n = 1'b1;
    send(16'h2822, 1'b1, 1'b0, 1'b0, 2);
    send(16'hAAAA, 1'b0, 1'b1, 1'b0, 2);
    send(16'h5555, 1'b0, 1'b1, 1'b0, 2);
    exp_q = '{20'h62822, 20'h1AAAA, 20'h95555};
    good_msg();
    settle(5, "basic");
    own_msg(16'h2820);
    settle(5, "wc32");
    partial(16'h2823, 2);
    exp_mark(2);
    settle(260, "gap");
    send(16'h2823, 1'b1, 1'b0, 1'b0, 2);
    send(16'h1111, 1'b0, 1'b1, 1'b0, 2);
    send(16'h2222, 1'b0, 1'b1, 1'b1, 2);
    send(16'h3333, 1'b0, 1'b1, 1'b0, 2);
    exp_q = '{20'h62823, 20'h11111};
    exp_mark(1);
    settle(5, "parity");
    send(16'h2C20, 1'b1, 1'b0, 1'b0, 2);
    exp_q = '{20'hE2C20};
    good_msg();
    settle(5, "after_parity");
    send(16'h4824, 1'b1, 1'b0, 1'b0, 2);
    junk(4);
    send(16'h2C20, 1'b1, 1'b0, 1'b0, 2);
    exp_q = '{20'hE2C20};
    good_msg();
    settle(5, "foreign_rt");
    partial(16'h2823, 1);
    fifo_full = 1'b1;
    send(16'h7777, 1'b0, 1'b1, 1'b0, 0);
    repeat (3) @(negedge dec_clk);
    check("ovf/hold", fifo_wren, 0);
    fifo_full = 1'b0;
    @(negedge dec_clk);
    check("ovf/wren", fifo_wren, 1);
    check("ovf/marker", fifo_din, 20'h30004);
    exp_mark(4);
    settle(5, "overflow");
    send(16'h1234, 1'b0, 1'b1, 1'b0, 2);
    exp_mark(3);
    settle(5, "idle_data");
`ifdef BCAST_EN
    own_msg(16'hF822);
`else
    send(16'hF822, 1'b1, 1'b0, 1'b0, 2);
    junk(2);
`endif
    settle(5, "bcast");
    partial(16'h2825, 1);
    settle(3, "pre_reset");
    @(negedge dec_clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst/wren", fifo_wren, 0);
    check("mid_rst/cnt", msg_cnt, 0);
    check("mid_rst/code", err_code, 0);
    repeat (2) @(negedge dec_clk);
    rst_n = 1'b1;
    e_cnt = '0;
    e_code = '0;
    settle(300, "post_reset");
    for (int s = 0; s < 60; s++) begin
      rt_addr = 5'($urandom_range(0, 30));
      kind = $urandom_range(0, 7);
      c = rcv_cmd(rt_addr);
      n = n_data(c);
      if (kind <= 1) begin
        own_msg({rt_addr, 11'($urandom)});
        ign = 1'b0;
      end else if (kind == 2) begin
        send(rcv_cmd(5'((int'(rt_addr) + $urandom_range(1, 30)) % 31)), 1'b1, 1'b0, 1'b0, 2);
        junk($urandom_range(0, 4));
        ign = 1'b1;
      end else if (kind == 3) begin
        partial(c, $urandom_range(0, n - 1));
        exp_mark(2);
        ign = 1'b0;
      end else if (kind == 4) begin
        k = $urandom_range(0, n - 1);
        partial(c, k);
        send(16'($urandom), 1'b0, 1'b1, 1'b1, 2);
        exp_mark(1);
        junk(n - k - 1);
        ign = 1'b1;
      end else if (kind == 5) begin
        partial(c, $urandom_range(0, n - 1));
        exp_mark(5);
        own_msg({rt_addr, 11'($urandom)});
        ign = 1'b0;
      end else if (kind == 6) begin
        partial(c, $urandom_range(0, n - 1));
        fifo_full = 1'b1;
        send(16'($urandom), 1'b0, 1'b1, 1'b0, $urandom_range(0, 4));
        fifo_full = 1'b0;
        exp_mark(4);
        ign = 1'b0;
      end else begin
        send(16'($urandom), 1'b0, 1'b1, 1'b0, 2);
        if (!ign) exp_mark(3);
      end
      settle(kind == 3 ? 260 : 8, $sformatf("rand%0d_k%0d", s, kind));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
